// File: rtl/bp_update_queue.sv
// In-order queue of retired branch outcomes from two commit lanes feeding the single predictor update port.
// Entries appear on upd_* the cycle after enqueue; commit is refused while fewer than two slots are free, and updates stall on upd_ready_i=0.
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c0_valid_i,
    input  logic [63:0]              c0_pc_i,
    input  logic                     c0_taken_i,
    input  logic [63:0]              c0_target_i,
    input  logic                     c0_is_branch_i,
    input  logic                     c0_is_indirect_i,
    input  logic                     c1_valid_i,
    input  logic [63:0]              c1_pc_i,
    input  logic                     c1_taken_i,
    input  logic [63:0]              c1_target_i,
    input  logic                     c1_is_branch_i,
    input  logic                     c1_is_indirect_i,
    output logic                     commit_ready_o,
    output logic                     upd_valid_o,
    output logic [63:0]              upd_pc_o,
    output logic                     upd_taken_o,
    output logic [63:0]              upd_target_o,
    output logic                     upd_is_branch_o,
    output logic                     upd_is_indirect_o,
    input  logic                     upd_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     idle_o,
    output logic [CNT_W-1:0]         issued_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target;
        logic        taken;
        logic        is_branch;
        logic        is_indirect;
    } upd_ent_t;

    upd_ent_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    logic       c0_qual, c1_qual, enq_fire, deq;
    logic [1:0] enq_num;
    upd_ent_t   lane0_ent, lane1_ent, first_ent, head_ent;

    assign c0_qual = c0_valid_i & (c0_is_branch_i | c0_is_indirect_i);
    assign c1_qual = c1_valid_i & (c1_is_branch_i | c1_is_indirect_i);

    assign lane0_ent = '{pc: c0_pc_i, target: c0_target_i, taken: c0_taken_i,
                         is_branch: c0_is_branch_i, is_indirect: c0_is_indirect_i};
    assign lane1_ent = '{pc: c1_pc_i, target: c1_target_i, taken: c1_taken_i,
                         is_branch: c1_is_branch_i, is_indirect: c1_is_indirect_i};

    // A lone qualifying lane 1 takes the first slot so entries stay packed.
    assign first_ent = c0_qual ? lane0_ent : lane1_ent;

    assign commit_ready_o = (count_q <= OCC_W'(DEPTH - 2));
    assign enq_fire       = commit_ready_o;
    assign enq_num        = enq_fire ? ({1'b0, c0_qual} + {1'b0, c1_qual}) : 2'd0;

    assign upd_valid_o = (count_q != '0);
    assign deq         = upd_valid_o & upd_ready_i;

    assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    assign wr_ptr_d  = wr_ptr_q + PTR_W'(enq_num);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(deq);
    assign count_d   = count_q + OCC_W'(enq_num) - OCC_W'(deq);
    assign issued_d  = (deq && (issued_q != '1)) ? issued_q + CNT_W'(1) : issued_q;

    // Storage is not reset; the head is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (enq_num != 2'd0) begin
                mem_q[wr_ptr_q] <= first_ent;
            end
            if (enq_num == 2'd2) begin
                mem_q[wr_ptr_nx] <= lane1_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    assign head_ent = upd_valid_o ? mem_q[rd_ptr_q] : '0;

    assign upd_pc_o          = head_ent.pc;
    assign upd_taken_o       = head_ent.taken;
    assign upd_target_o      = head_ent.target;
    assign upd_is_branch_o   = head_ent.is_branch;
    assign upd_is_indirect_o = head_ent.is_indirect;

    assign count_o      = count_q;
    assign idle_o       = (count_q == '0);
    assign issued_cnt_o = issued_q;
endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- Commit-side controller for the combined branch predictor update port.
- Collects retire-time branch outcomes from two commit lanes into a small in-order queue.
- Hands them to the predictor's single update interface at most one per cycle, using a valid/ready handshake so the predictor can stall updates (e.g. during lookup/update port conflicts).
- Non-branch retirements are filtered out, so predictor update bandwidth is spent only on branches.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.
- CNT_W, 16, width of the saturating issued-update counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- c0_valid_i  in  1  commit lane 0 retiring an instruction (older of the two).
- c0_pc_i  in  64  lane 0 PC.
- c0_taken_i  in  1  lane 0 resolved direction.
- c0_target_i  in  64  lane 0 resolved target.
- c0_is_branch_i  in  1  lane 0 is a direct branch (cond or uncond).
- c0_is_indirect_i  in  1  lane 0 is an indirect branch.
- c1_valid_i, c1_pc_i, c1_taken_i, c1_target_i, c1_is_branch_i, c1_is_indirect_i  in  1/64/1/64/1/1  lane 1 equivalents (younger).
- commit_ready_o  out  1  queue can accept this cycle's commit group.
- upd_valid_o  out  1  head entry presented to predictor.
- upd_pc_o  out  64  head PC.
- upd_taken_o  out  1  head direction.
- upd_target_o  out  64  head target.
- upd_is_branch_o  out  1  head is_branch flag.
- upd_is_indirect_o  out  1  head is_indirect flag.
- upd_ready_i  in  1  predictor accepts head this cycle.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- idle_o  out  1  queue empty.
- issued_cnt_o  out  CNT_W  saturating count of updates handed off.

Behaviour:
- Lane qualification: lane k qualifies = ck_valid_i & (ck_is_branch_i | ck_is_indirect_i). Non-qualifying valid lanes are accepted but not stored.
- commit_ready_o = (count <= DEPTH-2). It is combinational from registered count only, with no dependence on same-cycle inputs or upd_ready_i.
- Enqueue fires when commit_ready_o is 1.
  - Both lanes qualifying: lane 0 written at wr_ptr, lane 1 at wr_ptr+1; wr_ptr advances by 2.
  - Only one lane qualifying (either lane): it is written at wr_ptr; wr_ptr advances by 1.
  - No lane qualifying: no write.
- When commit_ready_o=0, inputs are ignored. Commit must hold its group; the queue does not latch it.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Wrap-around is transparent to ordering.
- Dequeue fires when upd_valid_o & upd_ready_i; rd_ptr advances by 1.
- Head output and flow-through:
  - upd_valid_o = (count != 0).
  - upd_* = entry at rd_ptr, read combinationally from storage.
  - No enqueue-to-output bypass: an entry enqueued in cycle N is first visible on upd_* in cycle N+1.
- count_next = count + enq_num - deq.
  - Simultaneous enqueue and dequeue are legal in the same cycle.
  - A full queue (count=DEPTH) can still dequeue; it accepts new entries only once count <= DEPTH-2.
- Outputs are stable while upd_valid_o=1 & upd_ready_i=0: head entry and its fields are held unchanged.
- Ordering is strict: output order equals commit order (lane 0 before lane 1, earlier cycles first).
- issued_cnt_o increments by 1 per dequeue and saturates at all-ones (no wrap).
- idle_o = (count == 0).
- Reset (rst=1 at an edge, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, issued_cnt_o=0.
  - Stored entries are discarded; storage contents need not be cleared.
  - After reset: upd_valid_o=0, commit_ready_o=1, idle_o=1, count_o=0.
  - Inputs in the reset cycle are ignored.
- No X propagation: when upd_valid_o=0, upd_* may hold stale data but must not be X after the first write. Storage is zero-initialised on reset or masked to 0 when empty.

Test Plan:
- Reset then single branch: c0 valid, pc=0x1000, taken=1, target=0x2000, is_branch=1, upd_ready_i=1 -> next cycle upd_valid_o=1, upd_pc_o=0x1000, upd_target_o=0x2000. The following cycle idle_o=1 and issued_cnt_o=1.
- Dual-lane ordering plus filtering:
  - Cycle 1: c0 pc=0x100 is_branch, c1 pc=0x104 is_indirect.
  - Cycle 2: c0 pc=0x200 non-branch, c1 pc=0x204 is_branch.
  - upd_ready_i=1 -> upd_pc_o sequence 0x100, 0x104, 0x204; count_o never exceeds 2; 0x200 never appears.
- Backpressure/full (DEPTH=8): upd_ready_i=0 with 4 cycles of dual-branch commits -> count_o=6 then 8; commit_ready_o=0 when count=7 or 8. The 5th group is held and not stored. Then upd_ready_i=1 -> commit_ready_o returns to 1 once count<=6, and 8 entries drain in order.
- Simultaneous enq/deq with wrap:
  - Stream one branch per cycle for 20 cycles with upd_ready_i=1; pointers wrap twice.
  - -> count_o stays 1 after first cycle; output PCs match input order with 1-cycle latency; issued_cnt_o=20 at end.
- Stall hold: queue holds 3 entries, upd_ready_i=0 for 5 cycles -> upd_pc_o and other upd_* constant, count_o=3 throughout.
- Reset mid-operation: count_o=5, assert rst one cycle -> next cycle count_o=0, upd_valid_o=0, commit_ready_o=1, issued_cnt_o=0. Commits in the reset cycle are not stored.
